// File: rtl/operand_fetch_if.sv
// Bus bundle between decode, register file, writeback and execute for the operand fetch stage.
// The master modport is the environment side; the slave modport is the stage itself.
interface operand_fetch_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_src0;
    logic [ADDR_W-1:0] in_src1;
    logic [ADDR_W-1:0] in_dst;
    logic              in_dst_we;
    logic [ADDR_W-1:0] rf_raddr0;
    logic [ADDR_W-1:0] rf_raddr1;
    logic [DATA_W-1:0] rf_rdata0;
    logic [DATA_W-1:0] rf_rdata1;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_op0;
    logic [DATA_W-1:0] out_op1;
    logic [ADDR_W-1:0] out_dst;
    logic              out_dst_we;

    modport master (
        output in_valid, in_src0, in_src1, in_dst, in_dst_we,
        input  in_ready,
        input  rf_raddr0, rf_raddr1,
        output rf_rdata0, rf_rdata1,
        output wb_valid, wb_addr, wb_data,
        input  out_valid, out_op0, out_op1, out_dst, out_dst_we,
        output out_ready
    );

    modport slave (
        input  in_valid, in_src0, in_src1, in_dst, in_dst_we,
        output in_ready,
        output rf_raddr0, rf_raddr1,
        input  rf_rdata0, rf_rdata1,
        input  wb_valid, wb_addr, wb_data,
        output out_valid, out_op0, out_op1, out_dst, out_dst_we,
        input  out_ready
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch / issue stage: reads the register file with writeback bypass, blocks on
// scoreboard hazards and holds one registered operand bundle for execute.
module operand_fetch #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    operand_fetch_if.slave   bus,
    output logic [CNT_W-1:0] stall_count
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic {EMPTY, FULL} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   op0_q, op0_d;
    logic [DATA_W-1:0]   op1_q, op1_d;
    logic [ADDR_W-1:0]   dst_q, dst_d;
    logic                dst_we_q, dst_we_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]    stall_q, stall_d;

    logic [NUM_REGS-1:0] clr;
    logic [DATA_W-1:0]   op0, op1;
    logic                hazard;
    logic                in_ready;
    logic                accept;

    assign bus.rf_raddr0 = bus.in_src0;
    assign bus.rf_raddr1 = bus.in_src1;

    // A register whose writeback lands this cycle is no longer a hazard: its value is bypassed.
    always_comb begin
        for (int a = 0; a < NUM_REGS; a++) begin
            clr[a] = bus.wb_valid && (bus.wb_addr == ADDR_W'(a));
        end
    end

    assign op0 = (bus.wb_valid && bus.wb_addr == bus.in_src0) ? bus.wb_data : bus.rf_rdata0;
    assign op1 = (bus.wb_valid && bus.wb_addr == bus.in_src1) ? bus.wb_data : bus.rf_rdata1;

    assign hazard = (pending_q[bus.in_src0] && !clr[bus.in_src0])
                 || (pending_q[bus.in_src1] && !clr[bus.in_src1])
                 || (bus.in_dst_we && pending_q[bus.in_dst] && !clr[bus.in_dst]);

    assign in_ready = ((state_q == EMPTY) || bus.out_ready) && !hazard;
    assign accept   = bus.in_valid && in_ready;

    // NOTE: every signal gets its hold value first so no path through this block infers a latch.
    always_comb begin
        state_d  = state_q;
        op0_d    = op0_q;
        op1_d    = op1_q;
        dst_d    = dst_q;
        dst_we_d = dst_we_q;
        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL: begin
                if (bus.out_ready && !accept) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
        if (accept) begin
            op0_d    = op0;
            op1_d    = op1;
            dst_d    = bus.in_dst;
            dst_we_d = bus.in_dst_we;
        end
    end

    // Set wins over a same-cycle clear, so a fresh writer stays tracked.
    always_comb begin
        pending_d = pending_q;
        for (int a = 0; a < NUM_REGS; a++) begin
            if (accept && bus.in_dst_we && (bus.in_dst == ADDR_W'(a))) pending_d[a] = 1'b1;
            else if (clr[a])                                           pending_d[a] = 1'b0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (bus.in_valid && !in_ready && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            op0_q     <= '0;
            op1_q     <= '0;
            dst_q     <= '0;
            dst_we_q  <= 1'b0;
            pending_q <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            op0_q     <= op0_d;
            op1_q     <= op1_d;
            dst_q     <= dst_d;
            dst_we_q  <= dst_we_d;
            pending_q <= pending_d;
            stall_q   <= stall_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = (state_q == FULL);
    assign bus.out_op0    = op0_q;
    assign bus.out_op1    = op1_q;
    assign bus.out_dst    = dst_q;
    assign bus.out_dst_we = dst_we_q;
    assign stall_count    = stall_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: issue, RAW/WAW stalls, bypass, backpressure,
// async reset and stall counter saturation (counter narrowed to 4 bits).
module tb_operand_fetch;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 2;
    localparam int CNT_W  = 4;

    logic clk;
    logic rst_n;
    logic [CNT_W-1:0]  stall_count;
    logic [DATA_W-1:0] rf [4];

    int checks;
    int errors;

    operand_fetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    operand_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .stall_count (stall_count)
    );

    assign bus.rf_rdata0 = rf[bus.rf_raddr0];
    assign bus.rf_rdata1 = rf[bus.rf_raddr1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] s0, input logic [1:0] s1,
                         input logic [1:0] d, input logic we);
        bus.in_valid  = 1'b1;
        bus.in_src0   = s0;
        bus.in_src1   = s1;
        bus.in_dst    = d;
        bus.in_dst_we = we;
    endtask

    // Packed view of the visible bundle: {valid, dst_we, dst, op0, op1}.
    function automatic logic [67:0] bundle();
        return {bus.out_valid, bus.out_dst_we, bus.out_dst, bus.out_op0, bus.out_op1};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_src0 = 2'd2; bus.in_src1 = 2'd1;
        bus.in_dst = 2'd0; bus.in_dst_we = 1'b0;
        bus.wb_valid = 1'b0; bus.wb_addr = 2'd0; bus.wb_data = '0;
        bus.out_ready = 1'b0;
        rf[0] = 32'h5; rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33;
        tick(); tick();
        checks++;
        if (bundle() !== 68'h0) begin
            errors++; $display("FAIL reset_bundle got %h want 0", bundle());
        end
        checks++;
        if (stall_count !== 4'd0 || dut.pending_q !== 4'b0000) begin
            errors++; $display("FAIL reset_state stall %0d pending %b want 0 0000", stall_count, dut.pending_q);
        end
        checks++;
        if ({bus.rf_raddr0, bus.rf_raddr1} !== {2'd2, 2'd1}) begin
            errors++; $display("FAIL raddr_comb got %0d %0d want 2 1", bus.rf_raddr0, bus.rf_raddr1);
        end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_basic_issue();
        tick();
        issue(2'd1, 2'd2, 2'd3, 1'b1);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_ready got %b want 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bundle() !== {1'b1, 1'b1, 2'd3, 32'h11, 32'h22}) begin
            errors++; $display("FAIL basic_bundle got %h want %h", bundle(), {1'b1, 1'b1, 2'd3, 32'h11, 32'h22});
        end
        checks++;
        if (dut.pending_q !== 4'b1000) begin
            errors++; $display("FAIL basic_pending got %b want 1000", dut.pending_q);
        end
    endtask

    task automatic test_raw_stall();
        bus.out_ready = 1'b1;
        issue(2'd3, 2'd0, 2'd0, 1'b0);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL raw_blocked got %b want 0", bus.in_ready);
        end
        tick(); tick();
        checks++;
        if (stall_count !== 4'd2 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL raw_stall_count got %0d valid %b want 2 0", stall_count, bus.out_valid);
        end
        bus.wb_valid = 1'b1; bus.wb_addr = 2'd3; bus.wb_data = 32'hABCD;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL raw_release got %b want 1", bus.in_ready);
        end
        tick();
        rf[3] = 32'hABCD;
        bus.wb_valid = 1'b0;
        checks++;
        if (bundle() !== {1'b1, 1'b0, 2'd0, 32'hABCD, 32'h5}) begin
            errors++; $display("FAIL raw_bypass got %h want %h", bundle(), {1'b1, 1'b0, 2'd0, 32'hABCD, 32'h5});
        end
        checks++;
        if (dut.pending_q !== 4'b0000 || stall_count !== 4'd2) begin
            errors++; $display("FAIL raw_after pending %b stall %0d want 0000 2", dut.pending_q, stall_count);
        end
    endtask

    task automatic test_backpressure();
        logic [67:0] held;
        held = {1'b1, 1'b0, 2'd0, 32'hABCD, 32'h5};
        bus.out_ready = 1'b0;
        issue(2'd1, 2'd2, 2'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bundle() !== held || bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold cycle %0d got %h ready %b want %h 0", i, bundle(), bus.in_ready, held);
            end
            tick();
        end
        checks++;
        if (stall_count !== 4'd7) begin
            errors++; $display("FAIL bp_stall_count got %0d want 7", stall_count);
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got %b want 1", bus.in_ready);
        end
        tick();
        checks++;
        if (bundle() !== {1'b1, 1'b1, 2'd1, 32'h11, 32'h22}) begin
            errors++; $display("FAIL bp_load got %h want %h", bundle(), {1'b1, 1'b1, 2'd1, 32'h11, 32'h22});
        end
        issue(2'd2, 2'd2, 2'd2, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bundle() !== {1'b1, 1'b1, 2'd2, 32'h22, 32'h22} || dut.pending_q !== 4'b0110) begin
            errors++; $display("FAIL b2b_load got %h pending %b want %h 0110", bundle(), dut.pending_q, {1'b1, 1'b1, 2'd2, 32'h22, 32'h22});
        end
    endtask

    task automatic test_waw();
        issue(2'd0, 2'd0, 2'd2, 1'b1);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL waw_blocked got %b want 1'b0", bus.in_ready);
        end
        tick();
        checks++;
        if (stall_count !== 4'd8) begin
            errors++; $display("FAIL waw_stall_count got %0d want 8", stall_count);
        end
        bus.wb_valid = 1'b1; bus.wb_addr = 2'd2; bus.wb_data = 32'h77;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL waw_release got %b want 1", bus.in_ready);
        end
        tick();
        rf[2] = 32'h77;
        bus.wb_valid = 1'b0; bus.in_valid = 1'b0;
        checks++;
        if (bundle() !== {1'b1, 1'b1, 2'd2, 32'h5, 32'h5} || dut.pending_q !== 4'b0110) begin
            errors++; $display("FAIL waw_set_wins got %h pending %b want %h 0110", bundle(), dut.pending_q, {1'b1, 1'b1, 2'd2, 32'h5, 32'h5});
        end
    endtask

    task automatic test_bypass();
        bus.wb_valid = 1'b1; bus.wb_addr = 2'd0; bus.wb_data = 32'h99;
        issue(2'd0, 2'd0, 2'd0, 1'b0);
        tick();
        bus.wb_valid = 1'b0;
        rf[0] = 32'h99;
        checks++;
        if (bundle() !== {1'b1, 1'b0, 2'd0, 32'h99, 32'h99} || dut.pending_q !== 4'b0110) begin
            errors++; $display("FAIL wb_nonpending got %h pending %b want %h 0110", bundle(), dut.pending_q, {1'b1, 1'b0, 2'd0, 32'h99, 32'h99});
        end
        issue(2'd3, 2'd3, 2'd3, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bundle() !== {1'b1, 1'b1, 2'd3, 32'hABCD, 32'hABCD} || dut.pending_q !== 4'b1110) begin
            errors++; $display("FAIL src_eq_dst got %h pending %b want %h 1110", bundle(), dut.pending_q, {1'b1, 1'b1, 2'd3, 32'hABCD, 32'hABCD});
        end
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bundle() !== 68'h0 || dut.pending_q !== 4'b0000 || stall_count !== 4'd0) begin
            errors++; $display("FAIL async_reset got %h pending %b stall %0d want 0 0000 0", bundle(), dut.pending_q, stall_count);
        end
        tick();
        #2 rst_n = 1'b1;
    endtask

    task automatic test_saturation();
        bus.out_ready = 1'b1;
        tick();
        issue(2'd0, 2'd0, 2'd1, 1'b1);
        tick();
        checks++;
        if (bundle() !== {1'b1, 1'b1, 2'd1, 32'h99, 32'h99} || stall_count !== 4'd0) begin
            errors++; $display("FAIL sat_setup got %h stall %0d want %h 0", bundle(), stall_count, {1'b1, 1'b1, 2'd1, 32'h99, 32'h99});
        end
        issue(2'd1, 2'd0, 2'd0, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (stall_count !== 4'd15) begin
            errors++; $display("FAIL sat_reach got %0d want 15", stall_count);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (stall_count !== 4'd15) begin
            errors++; $display("FAIL sat_hold got %0d want 15", stall_count);
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_issue();
        test_raw_stall();
        test_backpressure();
        test_waw();
        test_bypass();
        test_async_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Issue stage directly upstream of the 4-entry register file.
- Accepts decoded instructions (two source addresses, one destination), drives the register-file read addresses and captures the operands.
- Bypasses same-cycle writeback data and tracks outstanding writes with a per-register scoreboard.
- Presents one registered operand bundle to execute over a valid/ready handshake.

Parameters:
DATA_W, 32, operand/data width
ADDR_W, 2, register address width; NUM_REGS = 2**ADDR_W (4)
CNT_W, 16, width of stall-cycle counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decoded instruction present
in_ready  out  1  stage accepts instruction this cycle
in_src0  in  ADDR_W  source 0 register address
in_src1  in  ADDR_W  source 1 register address
in_dst  in  ADDR_W  destination register address
in_dst_we  in  1  instruction will write in_dst
rf_raddr0  out  ADDR_W  register file read address port 0
rf_raddr1  out  ADDR_W  register file read address port 1
rf_rdata0  in  DATA_W  register file read data port 0 (combinational)
rf_rdata1  in  DATA_W  register file read data port 1 (combinational)
wb_valid  in  1  writeback this cycle (same cycle as register file write)
wb_addr  in  ADDR_W  writeback register address
wb_data  in  DATA_W  writeback data
out_valid  out  1  operand bundle valid
out_ready  in  1  execute accepts bundle
out_op0  out  DATA_W  operand 0
out_op1  out  DATA_W  operand 1
out_dst  out  ADDR_W  destination address
out_dst_we  out  1  destination write flag
stall_count  out  CNT_W  cycles with in_valid=1 and in_ready=0, saturating

Behaviour:
- Clocking and reset: single clock domain. Reset is asynchronous assert, active-low (rst_n).
- Reset values: out_valid=0, out_op0=0, out_op1=0, out_dst=0, out_dst_we=0, pending[*]=0, stall_count=0.
- Reset mid-operation drops any held bundle; a pending write is forgotten.
- Read addresses: rf_raddr0=in_src0 and rf_raddr1=in_src1 combinationally, always, regardless of in_valid.
- Bypass: opN = (wb_valid && wb_addr==in_srcN) ? wb_data : rf_rdataN. Compare is full-width, no masking.
- Scoreboard: pending[NUM_REGS-1:0].
  - clr(a) = wb_valid && wb_addr==a.
  - haz_src(N) = pending[in_srcN] && !clr(in_srcN).
  - haz_waw = in_dst_we && pending[in_dst] && !clr(in_dst).
  - hazard = haz_src(0) || haz_src(1) || haz_waw.
- in_ready = (!out_valid || out_ready) && !hazard. Purely combinational; may be 1 while in_valid=0.
- Accept = in_valid && in_ready. On accept the stage captures op0, op1, in_dst and in_dst_we into the output registers next edge and sets out_valid=1.
- Output state machine:
  - EMPTY (out_valid=0): accept -> FULL; else stay EMPTY.
  - FULL (out_valid=1):
    - out_ready && accept -> FULL, with new bundle loaded (back-to-back, 1 instruction/cycle).
    - out_ready && !accept -> EMPTY.
    - !out_ready -> hold every output stable.
- Latency: accept on cycle N -> bundle visible at out_* on cycle N+1.
- Pending update each edge, per register a:
  - set if accept && in_dst_we && in_dst==a;
  - else clear if clr(a);
  - else hold.
  - Simultaneous set and clear of the same address: set wins.
- wb_valid to a non-pending register: scoreboard unchanged; data is still bypassed.
- Source equal to destination of the same instruction: uses the old value. The pending bit is set only after the read.
- stall_count: increments by 1 on each cycle with in_valid && !in_ready. Saturates at 2**CNT_W-1; no wrap. Cleared only by reset.
- No combinational path from out_ready to out_* data. The only out_ready -> in_ready path is through the EMPTY/FULL term.

Test Plan:
- Reset and basic issue: hold rst_n=0, check all outputs are 0. Release; RF holds r1=0x11, r2=0x22. Issue src0=1, src1=2, dst=3, we=1 -> next cycle out_valid=1, op0=0x11, op1=0x22, out_dst=3, pending[3]=1.
- RAW stall then release: next instruction src0=3 with out_ready=1 -> in_ready=0, stall_count increments each cycle. When wb_valid=1, wb_addr=3, wb_data=0xABCD the same cycle -> in_ready=1, captured op0=0xABCD (bypass), pending[3]=0.
- Backpressure: out_ready=0 for 5 cycles with FULL stage -> outputs stable, in_ready=0, stall_count +5 when in_valid=1. Then out_ready=1 plus a new instruction -> back-to-back load with no bubble.
- WAW and set-wins: pending[2]=1; issue dst=2 we=1 without wb -> stall. Issue dst=2 with wb_addr=2 the same cycle -> accepted, pending[2] remains 1.
- Async reset mid-operation: assert rst_n=0 between edges while FULL with pending[1]=1 -> out_valid=0 and pending=0 immediately, without waiting for a clock edge.
- Saturation: with CNT_W=4, hold in_valid=1 with a hazard for 20 cycles -> stall_count stops at 15.
